de1_soc_d8m_rtl: RTL and testbench
==================================

# de1_soc_d8m_rtl

Video output core of the DE1-SoC + D8M camera system. It generates 640x480@60 Hz VGA timing from the 50 MHz board clock and exposes the raster position as `VGA_H_CNT`/`VGA_V_CNT`. It produces the per-pixel colour `RED`/`GREEN`/`BLUE`, taken either from the camera frame-buffer read FIFO or from built-in test patterns. It drives the board VGA DAC pins.

## Interface
Parameters:
- H_SYNC_CYC, 96, horizontal sync width in pixels.
- H_SYNC_BACK, 48, horizontal back porch.
- H_SYNC_ACT, 640, active pixels per line.
- H_SYNC_FRONT, 16, horizontal front porch.
- H_SYNC_TOTAL, 800, pixels per line (sum of the four above).
- V_SYNC_CYC, 2, vertical sync width in lines.
- V_SYNC_BACK, 33, vertical back porch.
- V_SYNC_ACT, 480, active lines.
- V_SYNC_FRONT, 10, vertical front porch.
- V_SYNC_TOTAL, 525, lines per frame.

Ports:
- CLOCK_50  in  1  50 MHz system clock; the block's only clock.
- RESET  in  1  asynchronous, active-high reset.
- SW  in  [1:0]  pattern select.
- PIX_DATA  in  [23:0]  RGB888 from the frame-buffer FIFO ({R,G,B}); valid whenever PIX_EMPTY is 0.
- PIX_EMPTY  in  1  FIFO empty.
- PIX_RD  out  1  FIFO read strobe; one CLOCK_50 cycle per consumed pixel.
- VGA_CLK  out  1  25 MHz pixel clock.
- VGA_HS, VGA_VS  out  1  syncs, active low.
- VGA_BLANK_N  out  1  high in the active region.
- VGA_SYNC_N  out  1  constant 0.
- VGA_R, VGA_G, VGA_B  out  [7:0]  registered colour.
- VGA_H_CNT  out  [10:0]  horizontal counter, range 0..799.
- VGA_V_CNT  out  [9:0]  vertical counter, range 0..524.
- RED, GREEN, BLUE  out  [7:0]  combinational colour for the current (H,V).
- LEDR  out  [9:0]  bit0 sticky underrun; bits 9:1 frame counter.

## Operation
- `tick` register toggles every CLOCK_50 cycle. VGA_CLK = tick. The pixel enable `pe` = (tick==1).
- On `pe`:
  - H_CNT increments, wrapping 799→0.
  - On the H wrap, V_CNT increments, wrapping 524→0.
  - On the frame wrap (H=799, V=524), LEDR[9:1] increments modulo 512.
- Active region: 144 ≤ H ≤ 783 and 35 ≤ V ≤ 514.
  - Pixel x = H−144 (0..639).
  - Pixel y = V−35 (0..479).
- Combinational RED/GREEN/BLUE:
  - Outside the active region: 0.
  - Inside, by SW:
    - 00 camera: PIX_DATA[23:16]/[15:8]/[7:0] if PIX_EMPTY=0, else 0.
    - 01 colour bars, 8 bars of 80 px indexed x/80: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
    - 10 gray ramp: R=G=B=x[7:0] (wraps every 256 px).
    - 11 checkerboard: white when x[5]^y[5], else black.
- PIX_RD = pe & active & (SW==00) & ~PIX_EMPTY.
- Underrun: if pe & active & SW==00 & PIX_EMPTY, LEDR[0] sets to 1 and holds until RESET.
- Registered outputs, updated on `pe` from current-cycle values:
  - VGA_R/G/B ← RED/GREEN/BLUE.
  - VGA_HS ← ~(H < 96).
  - VGA_VS ← ~(V < 2).
  - VGA_BLANK_N ← active.
- SW changes take effect on the next pixel; no frame alignment.

## Timing
- Reset values: tick 0, H_CNT 0, V_CNT 0, LEDR 0, VGA_R/G/B 0, VGA_HS 0, VGA_VS 0, VGA_BLANK_N 0, VGA_CLK 0.
- RESET asserted mid-frame returns everything to the reset values immediately (asynchronous).
- After RESET deasserts:
  - The first rising edge sets tick=1.
  - The second edge is the first `pe`: H_CNT becomes 1.
- Pixel period: 2 CLOCK_50 cycles.
- Line: 1600 cycles.
- Frame: 840,000 cycles.
- VGA_* pin outputs lag the counters/RED/GREEN/BLUE by exactly one pixel (2 cycles). Syncs, blank and colour stay mutually aligned.
- PIX_RD is high only in the CLOCK_50 cycle where pe=1. The FIFO presents the next word before the next pe.
- H_CNT never reaches 800 and V_CNT never reaches 525.

## Test plan
- Reset, then run one full frame -> H_CNT/V_CNT sweep 0..799/0..524 with no out-of-range value. Frame wrap occurs at cycle 840,000 and LEDR[9:1]=1.
- SW=01, sample RED/GREEN/BLUE at V=100 -> H=144: FFFFFF; H=224: FFFF00; H=704: 000000; H=143: 000000.
- SW=10 -> at V=35, H=144: R=G=B=0; H=399: 255; H=400: 0.
- SW=00 with PIX_EMPTY=0 and PIX_DATA=123456 -> exactly 640×480 PIX_RD pulses per frame and RED=12, GREEN=34, BLUE=56 in the active region. LEDR[0] stays 0.
- SW=00 with PIX_EMPTY=1 -> colour 0, no PIX_RD, LEDR[0]=1 from the first active pixel. A following RESET clears it.
- Check VGA_HS low for 96 pixels per line and VGA_VS low for 2 lines. VGA_BLANK_N high for 640×480 pixels, one pixel after the counters. Assert RESET mid-line -> all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/de1_soc_d8m_rtl.sv
// de1_soc_d8m_rtl
//   VGA output core for the DE1-SoC + D8M camera system. Generates 640x480@60
//   timing from the 50 MHz board clock using a 25 MHz pixel enable. Pixel colour
//   comes either from the camera frame-buffer FIFO or from one of three built-in
//   test patterns. The VGA DAC pins are registered one pixel behind the raster
//   counters.
//
// Ports
//   CLOCK_50     in   50 MHz clock (only clock of the block)
//   RESET        in   asynchronous, active-high reset
//   SW[1:0]      in   pattern select: 00 camera, 01 bars, 10 gray ramp, 11 checker
//   PIX_DATA     in   {R,G,B} from the frame-buffer FIFO, valid when PIX_EMPTY=0
//   PIX_EMPTY    in   FIFO empty flag
//   PIX_RD       out  FIFO read strobe, one CLOCK_50 cycle per consumed pixel
//   VGA_CLK      out  25 MHz pixel clock
//   VGA_HS/VS    out  active-low syncs (registered)
//   VGA_BLANK_N  out  high during active video (registered)
//   VGA_SYNC_N   out  tied low
//   VGA_R/G/B    out  registered colour
//   VGA_H_CNT    out  horizontal raster counter 0..H_SYNC_TOTAL-1
//   VGA_V_CNT    out  vertical raster counter 0..V_SYNC_TOTAL-1
//   RED/GREEN/BLUE out combinational colour for the current raster position
//   LEDR[9:0]    out  bit0 sticky FIFO underrun, bits 9:1 frame counter

module de1_soc_d8m_rtl #(
  parameter int H_SYNC_CYC   = 96,
  parameter int H_SYNC_BACK  = 48,
  parameter int H_SYNC_ACT   = 640,
  parameter int H_SYNC_FRONT = 16,
  parameter int H_SYNC_TOTAL = 800,
  parameter int V_SYNC_CYC   = 2,
  parameter int V_SYNC_BACK  = 33,
  parameter int V_SYNC_ACT   = 480,
  parameter int V_SYNC_FRONT = 10,
  parameter int V_SYNC_TOTAL = 525
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [1:0]  SW,
  input  logic [23:0] PIX_DATA,
  input  logic        PIX_EMPTY,
  output logic        PIX_RD,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic [10:0] VGA_H_CNT,
  output logic [9:0]  VGA_V_CNT,
  output logic [7:0]  RED,
  output logic [7:0]  GREEN,
  output logic [7:0]  BLUE,
  output logic [9:0]  LEDR
);

  localparam logic [10:0] H_LAST      = 11'(H_SYNC_TOTAL - 1);
  localparam logic [10:0] H_SYNC_END  = 11'(H_SYNC_CYC);
  localparam logic [10:0] H_ACT_START = 11'(H_SYNC_CYC + H_SYNC_BACK);
  localparam logic [10:0] H_ACT_END   = 11'(H_SYNC_CYC + H_SYNC_BACK + H_SYNC_ACT);
  localparam logic [9:0]  V_LAST      = 10'(V_SYNC_TOTAL - 1);
  localparam logic [9:0]  V_SYNC_END  = 10'(V_SYNC_CYC);
  localparam logic [9:0]  V_ACT_START = 10'(V_SYNC_CYC + V_SYNC_BACK);
  localparam logic [9:0]  V_ACT_END   = 10'(V_SYNC_CYC + V_SYNC_BACK + V_SYNC_ACT);

  // The totals are given separately from the four segments; a mismatch would
  // silently shift the porches, so refuse to elaborate.
  generate
    if (H_SYNC_CYC + H_SYNC_BACK + H_SYNC_ACT + H_SYNC_FRONT != H_SYNC_TOTAL) begin : g_bad_h_total
      $error("horizontal timing segments do not add up to H_SYNC_TOTAL");
    end
    if (V_SYNC_CYC + V_SYNC_BACK + V_SYNC_ACT + V_SYNC_FRONT != V_SYNC_TOTAL) begin : g_bad_v_total
      $error("vertical timing segments do not add up to V_SYNC_TOTAL");
    end
  endgenerate

  logic        tick_reg;
  logic [10:0] h_cnt_reg;
  logic [9:0]  v_cnt_reg;
  logic [8:0]  frame_cnt_reg;
  logic        underrun_reg;
  logic [23:0] vga_rgb_reg;
  logic        hs_reg;
  logic        vs_reg;
  logic        blank_n_reg;

  logic        pe;
  logic        h_wrap;
  logic        v_wrap;
  logic        active;
  logic        camera_sel;
  logic [10:0] x_pix;
  logic        y_bit5;
  logic [6:0]  bar_ge;
  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb;
  logic [23:0] pix_rgb;

  // tick runs at half rate; the cycle where it is high is the pixel enable.
  assign pe     = tick_reg;
  assign h_wrap = (h_cnt_reg == H_LAST);
  assign v_wrap = (v_cnt_reg == V_LAST);
  assign active = (h_cnt_reg >= H_ACT_START) && (h_cnt_reg < H_ACT_END) &&
                  (v_cnt_reg >= V_ACT_START) && (v_cnt_reg < V_ACT_END);
  assign camera_sel = (SW == 2'b00);

  // Pixel coordinates are only meaningful inside the active window; outside it
  // they wrap, but every consumer is gated by active.
  assign x_pix  = h_cnt_reg - H_ACT_START;
  assign y_bit5 = 1'((v_cnt_reg - V_ACT_START) >> 5);

  // Colour-bar index = x/80, built as a thermometer of bar boundaries so no
  // divider is needed.
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_bar_edge
      assign bar_ge[gi-1] = (x_pix >= 11'(80 * gi));
    end
  endgenerate

  always_comb begin
    bar_idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      bar_idx = bar_idx + {2'b00, bar_ge[i]};
    end
  end

  always_comb begin
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    pix_rgb = 24'h000000;
    if (active) begin
      case (SW)
        2'b00:   pix_rgb = PIX_EMPTY ? 24'h000000 : PIX_DATA;
        2'b01:   pix_rgb = bar_rgb;
        2'b10:   pix_rgb = {x_pix[7:0], x_pix[7:0], x_pix[7:0]};
        default: pix_rgb = (x_pix[5] ^ y_bit5) ? 24'hFFFFFF : 24'h000000;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      tick_reg      <= 1'b0;
      h_cnt_reg     <= '0;
      v_cnt_reg     <= '0;
      frame_cnt_reg <= '0;
      underrun_reg  <= 1'b0;
      vga_rgb_reg   <= '0;
      hs_reg        <= 1'b0;
      vs_reg        <= 1'b0;
      blank_n_reg   <= 1'b0;
    end else begin
      tick_reg <= ~tick_reg;
      if (pe) begin
        h_cnt_reg <= h_wrap ? 11'd0 : h_cnt_reg + 11'd1;
        if (h_wrap) begin
          v_cnt_reg <= v_wrap ? 10'd0 : v_cnt_reg + 10'd1;
          if (v_wrap) begin
            frame_cnt_reg <= frame_cnt_reg + 9'd1;
          end
        end
        // Starved FIFO while the camera is on screen: latch until reset.
        if (active && camera_sel && PIX_EMPTY) begin
          underrun_reg <= 1'b1;
        end
        // Pin outputs capture this pixel's values, so they trail the
        // counters by exactly one pixel and stay aligned with each other.
        vga_rgb_reg <= pix_rgb;
        hs_reg      <= ~(h_cnt_reg < H_SYNC_END);
        vs_reg      <= ~(v_cnt_reg < V_SYNC_END);
        blank_n_reg <= active;
      end
    end
  end

  assign PIX_RD      = pe && active && camera_sel && !PIX_EMPTY;
  assign VGA_CLK     = tick_reg;
  assign VGA_HS      = hs_reg;
  assign VGA_VS      = vs_reg;
  assign VGA_BLANK_N = blank_n_reg;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = vga_rgb_reg[23:16];
  assign VGA_G       = vga_rgb_reg[15:8];
  assign VGA_B       = vga_rgb_reg[7:0];
  assign VGA_H_CNT   = h_cnt_reg;
  assign VGA_V_CNT   = v_cnt_reg;
  assign RED         = pix_rgb[23:16];
  assign GREEN       = pix_rgb[15:8];
  assign BLUE        = pix_rgb[7:0];
  assign LEDR        = {frame_cnt_reg, underrun_reg};

endmodule

// File: tb/tb_de1_soc_d8m_rtl.sv
// Testbench for de1_soc_d8m_rtl.
//   Two instances share stimulus: a shrunken-timing instance (s_*) that reaches
//   frame wraps and every pattern quickly, and a default 640x480 instance (d_*).
//   A raster model derives counters, colours and the one-pixel-late pin outputs
//   from the number of clock edges since reset release.

module tb_de1_soc_d8m_rtl;

  localparam int S_HC = 8, S_HB = 4, S_HA = 272, S_HF = 4, S_HT = 288;
  localparam int S_VC = 2, S_VB = 2, S_VA = 34,  S_VF = 1, S_VT = 39;
  localparam int S_FP = S_HT * S_VT;

  logic        CLOCK_50 = 1'b0;
  logic        RESET    = 1'b0;
  logic [1:0]  SW       = 2'b00;
  logic [23:0] PIX_DATA = 24'h0;
  logic        PIX_EMPTY = 1'b1;

  always #10 CLOCK_50 = ~CLOCK_50;

  logic        s_rd, s_clk, s_hs, s_vs, s_bl, s_sn;
  logic [7:0]  s_vr, s_vg, s_vb, s_r, s_g, s_b;
  logic [10:0] s_h;
  logic [9:0]  s_v, s_led;
  logic        d_rd, d_clk, d_hs, d_vs, d_bl, d_sn;
  logic [7:0]  d_vr, d_vg, d_vb, d_r, d_g, d_b;
  logic [10:0] d_h;
  logic [9:0]  d_v, d_led;

  de1_soc_d8m_rtl #(
    .H_SYNC_CYC(S_HC), .H_SYNC_BACK(S_HB), .H_SYNC_ACT(S_HA), .H_SYNC_FRONT(S_HF), .H_SYNC_TOTAL(S_HT),
    .V_SYNC_CYC(S_VC), .V_SYNC_BACK(S_VB), .V_SYNC_ACT(S_VA), .V_SYNC_FRONT(S_VF), .V_SYNC_TOTAL(S_VT)
  ) dut_s (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .SW(SW), .PIX_DATA(PIX_DATA), .PIX_EMPTY(PIX_EMPTY),
    .PIX_RD(s_rd), .VGA_CLK(s_clk), .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_bl),
    .VGA_SYNC_N(s_sn), .VGA_R(s_vr), .VGA_G(s_vg), .VGA_B(s_vb), .VGA_H_CNT(s_h),
    .VGA_V_CNT(s_v), .RED(s_r), .GREEN(s_g), .BLUE(s_b), .LEDR(s_led)
  );

  de1_soc_d8m_rtl dut_d (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .SW(SW), .PIX_DATA(PIX_DATA), .PIX_EMPTY(PIX_EMPTY),
    .PIX_RD(d_rd), .VGA_CLK(d_clk), .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_BLANK_N(d_bl),
    .VGA_SYNC_N(d_sn), .VGA_R(d_vr), .VGA_G(d_vg), .VGA_B(d_vb), .VGA_H_CNT(d_h),
    .VGA_V_CNT(d_v), .RED(d_r), .GREEN(d_g), .BLUE(d_b), .LEDR(d_led)
  );

  // Clock edges seen since reset was released.
  int n = 0;
  always @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) n <= 0;
    else       n <= n + 1;
  end

  int total_checks  = 0;
  int passed_checks = 0;
  int fail_prints   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total_checks++;
    if (got === want) begin
      passed_checks++;
    end else begin
      if (fail_prints < 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
      fail_prints++;
    end
  endtask

  function automatic logic [23:0] model_colour(input bit act, input int x, input int y,
                                               input logic [1:0] sw, input logic [23:0] d,
                                               input logic emp);
    logic [7:0] g;
    if (!act) return 24'h0;
    case (sw)
      2'b00: return emp ? 24'h0 : d;
      2'b01: begin
        case (x / 80)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      2'b10: begin
        g = 8'(x % 256);
        return {g, g, g};
      end
      default: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // Expected pin-register contents per instance (0 = small, 1 = default).
  logic [23:0] e_vrgb [2];
  logic        e_hs [2];
  logic        e_vs [2];
  logic        e_bl [2];
  logic        e_und [2];

  task automatic model_check(input int id, input int hc, input int hb, input int ha, input int hf,
                             input int vc, input int vb, input int va, input int vf,
                             input logic [10:0] h_a, input logic [9:0] v_a,
                             input logic [23:0] rgb_a, input logic rd_a, input logic clk_a,
                             input logic [23:0] vrgb_a, input logic hs_a, input logic vs_a,
                             input logic bl_a, input logic sn_a, input logic [9:0] led_a);
    int ht, vt, fp, p, q, h, v, frame;
    bit tick, act;
    logic [23:0] col;
    string tag;
    tag = (id == 0) ? "s" : "d";
    if (RESET) begin
      e_vrgb[id] = 24'h0; e_hs[id] = 1'b0; e_vs[id] = 1'b0; e_bl[id] = 1'b0; e_und[id] = 1'b0;
    end
    ht    = hc + hb + ha + hf;
    vt    = vc + vb + va + vf;
    fp    = ht * vt;
    p     = n / 2;
    q     = p % fp;
    h     = q % ht;
    v     = q / ht;
    frame = (p / fp) % 512;
    tick  = (n % 2) == 1;
    act   = (h >= hc + hb) && (h < hc + hb + ha) && (v >= vc + vb) && (v < vc + vb + va);
    col   = model_colour(act, h - (hc + hb), v - (vc + vb), SW, PIX_DATA, PIX_EMPTY);

    chk({tag, "_h_cnt"},   64'(h_a),   64'(h));
    chk({tag, "_v_cnt"},   64'(v_a),   64'(v));
    chk({tag, "_vga_clk"}, 64'(clk_a), 64'(tick));
    chk({tag, "_rgb"},     64'(rgb_a), 64'(col));
    chk({tag, "_pix_rd"},  64'(rd_a),  64'(tick && act && SW == 2'b00 && !PIX_EMPTY));
    chk({tag, "_vga_rgb"}, 64'(vrgb_a), 64'(e_vrgb[id]));
    chk({tag, "_hs_vs_bl_sn"}, 64'({hs_a, vs_a, bl_a, sn_a}),
        64'({e_hs[id], e_vs[id], e_bl[id], 1'b0}));
    chk({tag, "_ledr"}, 64'(led_a), 64'({frame[8:0], e_und[id]}));

    // On a pixel-enable cycle the pins pick up this pixel at the next edge.
    if (!RESET && tick) begin
      e_vrgb[id] = col;
      e_hs[id]   = !(h < hc);
      e_vs[id]   = !(v < vc);
      e_bl[id]   = act;
      if (act && SW == 2'b00 && PIX_EMPTY) e_und[id] = 1'b1;
    end
  endtask

  always @(negedge CLOCK_50) begin
    model_check(0, S_HC, S_HB, S_HA, S_HF, S_VC, S_VB, S_VA, S_VF,
                s_h, s_v, {s_r, s_g, s_b}, s_rd, s_clk, {s_vr, s_vg, s_vb}, s_hs, s_vs, s_bl, s_sn, s_led);
    model_check(1, 96, 48, 640, 16, 2, 33, 480, 10,
                d_h, d_v, {d_r, d_g, d_b}, d_rd, d_clk, {d_vr, d_vg, d_vb}, d_hs, d_vs, d_bl, d_sn, d_led);
  end

  // Wait (bounded) for the small instance to show raster position (v,h) with
  // VGA_CLK equal to on_pe; returns at that negedge.
  task automatic wait_at(input int v, input int h, input bit on_pe, input int budget, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge CLOCK_50);
      if (int'(s_h) == h && int'(s_v) == v && s_clk == on_pe) hit = 1'b1;
    end
    if (!hit) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic do_reset(input logic [1:0] sw, input logic emp);
    @(posedge CLOCK_50);
    #3;
    RESET = 1'b1;
    SW = sw;
    PIX_EMPTY = emp;
    repeat (2) @(posedge CLOCK_50);
    #3;
    RESET = 1'b0;
  endtask

  function automatic logic [63:0] pack_s();
    return {s_h, s_v, s_led, s_vr, s_vg, s_vb, s_hs, s_vs, s_bl, s_clk, s_rd};
  endfunction

  function automatic logic [63:0] pack_d();
    return {d_h, d_v, d_led, d_vr, d_vg, d_vb, d_hs, d_vs, d_bl, d_clk, d_rd};
  endfunction

  int rd_cnt;

  initial begin
    #1;
    RESET = 1'b1;
    SW = 2'b00;
    PIX_DATA = 24'h123456;
    PIX_EMPTY = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("reset_state_s", pack_s(), 64'd0);
    chk("reset_state_d", pack_d(), 64'd0);
    #2;
    RESET = 1'b0;

    // Camera mode, FIFO always full: one whole small frame.
    rd_cnt = 0;
    for (int i = 0; i < 2 * S_FP; i++) begin
      @(negedge CLOCK_50);
      if (s_rd) rd_cnt++;
      @(posedge CLOCK_50);
    end
    #1;
    chk("frame_pix_rd_count", 64'(rd_cnt), 64'd9248);
    chk("frame_wrap_ledr",    64'(s_led), 64'h002);
    chk("frame_wrap_hv",      64'({s_h, s_v}), 64'd0);
    chk("default_hv_at_22464", 64'({d_h, d_v}), 64'({11'd32, 10'd14}));
    wait_at(5, 100, 1'b0, 4000, "cam");
    chk("cam_rgb_active", 64'({s_r, s_g, s_b}), 64'h123456);
    wait_at(5, 100, 1'b1, 4, "cam_pe");
    chk("cam_pix_rd_on_pe", 64'(s_rd), 64'd1);

    // Colour bars.
    do_reset(2'b01, 1'b0);
    wait_at(10, 11,  1'b0, 20000, "bars_h11");
    chk("bars_h11_blank", 64'({s_r, s_g, s_b}), 64'h000000);
    wait_at(10, 12,  1'b0, 10, "bars_h12");
    chk("bars_white",  64'({s_r, s_g, s_b}), 64'hFFFFFF);
    wait_at(10, 92,  1'b0, 400, "bars_h92");
    chk("bars_yellow", 64'({s_r, s_g, s_b}), 64'hFFFF00);
    wait_at(10, 252, 1'b0, 400, "bars_h252");
    chk("bars_green",  64'({s_r, s_g, s_b}), 64'h00FF00);

    // Gray ramp.
    do_reset(2'b10, 1'b0);
    wait_at(4, 12,  1'b0, 6000, "gray_h12");
    chk("gray_x0",   64'({s_r, s_g, s_b}), 64'h000000);
    wait_at(4, 100, 1'b0, 400, "gray_h100");
    chk("gray_x88",  64'({s_r, s_g, s_b}), 64'h585858);
    wait_at(4, 267, 1'b0, 400, "gray_h267");
    chk("gray_x255", 64'({s_r, s_g, s_b}), 64'hFFFFFF);
    wait_at(4, 268, 1'b0, 10, "gray_h268");
    chk("gray_x256", 64'({s_r, s_g, s_b}), 64'h000000);

    // Checkerboard, switched mid-line without reset.
    @(posedge CLOCK_50);
    #1;
    SW = 2'b11;
    wait_at(36, 11, 1'b0, 30000, "chk_h11");
    chk("checker_inactive", 64'({s_r, s_g, s_b}), 64'h000000);
    wait_at(36, 12, 1'b0, 10, "chk_h12");
    chk("checker_x0_y32",  64'({s_r, s_g, s_b}), 64'hFFFFFF);
    wait_at(36, 44, 1'b0, 100, "chk_h44");
    chk("checker_x32_y32", 64'({s_r, s_g, s_b}), 64'h000000);
    wait_at(36, 76, 1'b0, 100, "chk_h76");
    chk("checker_x64_y32", 64'({s_r, s_g, s_b}), 64'hFFFFFF);

    // Camera mode with an empty FIFO: underrun from the first active pixel.
    do_reset(2'b00, 1'b1);
    wait_at(4, 12, 1'b1, 6000, "und");
    chk("underrun_before", 64'(s_led[0]), 64'd0);
    chk("underrun_no_rd",  64'(s_rd), 64'd0);
    @(posedge CLOCK_50);
    #1;
    chk("underrun_set", 64'(s_led[0]), 64'd1);
    repeat (5) @(posedge CLOCK_50);

    // Asynchronous reset mid-line.
    #3;
    RESET = 1'b1;
    #1;
    chk("midline_reset_s", pack_s(), 64'd0);
    chk("midline_reset_d", pack_d(), 64'd0);
    repeat (2) @(posedge CLOCK_50);
    #3;
    RESET = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #1;
    chk("after_reset_ledr", 64'(s_led), 64'd0);
    chk("after_reset_h",    64'(s_h), 64'd2);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
